// File: rtl/advanced_dff_if.sv
// advanced_dff_if: data/enable/output bundle for the enable-gated register.
//   i_data : value to store (WIDTH bits), driven by the master
//   i_en   : write enable, sampled on the rising clock edge, driven by the master
//   o_data : stored value (WIDTH bits), driven by the register (slave)
`timescale 1ns/100ps
interface advanced_dff_if #(
   parameter int unsigned WIDTH = 1
);
   logic [WIDTH-1:0] i_data;
   logic             i_en;
   logic [WIDTH-1:0] o_data;

   modport master (
      output i_data,
      output i_en,
      input  o_data
   );

   modport slave (
      input  i_data,
      input  i_en,
      output o_data
   );
endinterface

// File: rtl/advanced_dff.sv
// advanced_dff: enable-gated D register with asynchronous active-high reset.
//   i_clk       : clock, loads happen on its rising edge
//   i_rst       : async active-high reset, forces o_data to RESET_VALUE at once
//   bus.i_data  : data to store
//   bus.i_en    : write enable (level, sampled at rising edges)
//   bus.o_data  : stored value, driven straight from the flop
`timescale 1ns/100ps
module advanced_dff #(
   parameter int unsigned          WIDTH       = 1,
   parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
   input  logic          i_clk,
   input  logic          i_rst,
   advanced_dff_if.slave bus
);

   logic [WIDTH-1:0] data_d;
   logic [WIDTH-1:0] data_q;

   // Next value: load on enable, otherwise recirculate
   always_comb begin
      data_d = data_q;
      if (bus.i_en) begin
         data_d = bus.i_data;
      end
   end

   // Storage flop; reset takes priority over any enabled load
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         data_q <= RESET_VALUE;
      end else begin
         data_q <= data_d;
      end
   end

   assign bus.o_data = data_q;

endmodule

// File: tb/tb_advanced_dff.sv
// tb_advanced_dff: directed bench for advanced_dff, one 1-bit instance
// (RESET_VALUE 0) and one 8-bit instance (RESET_VALUE 8'hA5).
`timescale 1ns/100ps
module tb_advanced_dff;

   typedef struct {
      string      tag;
      logic [7:0] exp;
   } exp_t;

   logic clk = 1'b0;
   logic rst1 = 1'b0;
   logic rst8 = 1'b0;

   exp_t        sb_q[$];
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [7:0]  model8;

   advanced_dff_if #(.WIDTH(1)) bus1 ();
   advanced_dff_if #(.WIDTH(8)) bus8 ();

   advanced_dff #(.WIDTH(1), .RESET_VALUE(1'b0)) dut1 (
      .i_clk (clk),
      .i_rst (rst1),
      .bus   (bus1)
   );

   advanced_dff #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut8 (
      .i_clk (clk),
      .i_rst (rst8),
      .bus   (bus8)
   );

   // rising edges at t=1,3,5,...
   always #1 clk = ~clk;

   initial begin
      #5000;
      $display("FAIL watchdog: observed timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   task automatic push_exp(input string tag, input logic [7:0] e);
      exp_t x;
      x.tag = tag;
      x.exp = e;
      sb_q.push_back(x);
   endtask

   task automatic check_out(input logic [7:0] obs);
      exp_t x;
      n_checks++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty: observed %h, expected a queued value", obs);
      end else begin
         x = sb_q.pop_front();
         assert (obs === x.exp)
         else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", x.tag, obs, x.exp);
         end
      end
   endtask

   task automatic check1();
      check_out(8'(bus1.o_data));
   endtask

   task automatic check8();
      check_out(bus8.o_data);
   endtask

   // advance to one time unit after the next rising edge (a falling edge)
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [0:0] pat [5];
      pat = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

      bus1.i_en = 1'b0; bus1.i_data = 1'b0;
      bus8.i_en = 1'b0; bus8.i_data = 8'h00;

      // reset asserted with enable and data active: async clear
      #0.2;
      rst1 = 1'b1; rst8 = 1'b1;
      bus1.i_en = 1'b1; bus1.i_data = 1'b1;
      bus8.i_en = 1'b1; bus8.i_data = 8'h77;
      #0.1;
      push_exp("rst1_async", 8'h00); check1();
      push_exp("rst8_async", 8'hA5); check8();

      // reset held across edges
      repeat (3) begin
         push_exp("rst1_hold", 8'h00);
         push_exp("rst8_hold", 8'hA5);
         step();
         check1();
         check8();
      end

      // release reset, no enable: stays 0 even with data=1
      rst1 = 1'b0;
      bus1.i_en = 1'b0; bus1.i_data = 1'b1;
      repeat (3) begin
         push_exp("hold_no_en", 8'h00);
         step();
         check1();
      end

      // enabled write
      bus1.i_en = 1'b1;
      push_exp("en_write", 8'h01);
      step();
      check1();

      bus1.i_en = 1'b0;
      repeat (2) begin
         push_exp("write_retain", 8'h01);
         step();
         check1();
      end

      // data changes with enable low never reach the output
      bus1.i_data = 1'b0;
      repeat (3) begin
         push_exp("data_change_retain", 8'h01);
         step();
         check1();
      end

      // async reset pulse between edges
      #0.3;
      rst1 = 1'b1;
      #0.1;
      push_exp("rst_mid_cycle", 8'h00);
      check1();
      #0.2;
      rst1 = 1'b0;
      push_exp("after_rst_mid", 8'h00);
      step();
      check1();

      // enable pulse entirely between edges has no effect
      bus1.i_data = 1'b1;
      #0.3 bus1.i_en = 1'b1;
      #0.3 bus1.i_en = 1'b0;
      push_exp("en_glitch", 8'h00);
      step();
      check1();

      // enable and reset coincide at an edge: reset wins
      bus1.i_en = 1'b1; bus1.i_data = 1'b1; rst1 = 1'b1;
      push_exp("rst_en_edge", 8'h00);
      step();
      check1();

      // first edge after reset release loads normally
      rst1 = 1'b0;
      push_exp("first_edge_load", 8'h01);
      step();
      check1();

      // back-to-back enabled loads
      for (int i = 0; i < 5; i++) begin
         bus1.i_data = pat[i];
         push_exp("consecutive_load", 8'(pat[i]));
         step();
         check1();
      end

      // output constant between edges (sample just before next edge)
      bus1.i_en = 1'b0; bus1.i_data = 1'b0;
      #0.5;
      push_exp("mid_cycle_hold", 8'h01);
      check1();
      step();

      // 8-bit instance: release reset and write 3C
      rst8 = 1'b0;
      bus8.i_en = 1'b1; bus8.i_data = 8'h3C;
      push_exp("w8_write", 8'h3C);
      step();
      check8();

      bus8.i_en = 1'b0; bus8.i_data = 8'hFF;
      repeat (2) begin
         push_exp("w8_hold", 8'h3C);
         step();
         check8();
      end

      // random enable/data mix against a reference model
      model8 = 8'h3C;
      for (int i = 0; i < 10; i++) begin
         bus8.i_en   = 1'($urandom_range(0, 1));
         bus8.i_data = 8'($urandom);
         if (bus8.i_en) model8 = bus8.i_data;
         push_exp("w8_random", model8);
         step();
         check8();
      end

      // 8-bit async reset mid-operation
      bus8.i_en = 1'b1; bus8.i_data = 8'h12;
      #0.3;
      rst8 = 1'b1;
      #0.1;
      push_exp("w8_rst_mid", 8'hA5);
      check8();
      push_exp("w8_rst_en_edge", 8'hA5);
      step();
      check8();
      rst8 = 1'b0;
      push_exp("w8_post_rst_load", 8'h12);
      step();
      check8();

      if (sb_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_leftover: observed %0d entries, expected 0", sb_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
